multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Parametrised multicycle control FSM for the 18-bit register CPU.
//  Fetches an instruction over a ready handshake into an internal IR.
//  Sequences FETCH/DECODE/EXEC/MEM/WB and drives PC, register file, ALU and data memory.
//  Adds conditional jumps on ALU flags and registered, glitch-free controls.
// PARAMETERS
//  INSTR_W  18  instruction width; opcode=[INSTR_W-1 -: OPC_W], rd=[INSTR_W-OPC_W-1 -: REG_W], rs1=next REG_W bits
//  OPC_W    3   opcode width; 000 ADD(I),001 AND(I),010 NAND,011 NOR,100 LD,101 ST,110 CMP,111 JUMP
//  REG_W    4   register index width; rs2=IR[REG_W-1:0]
//  IMM_W    6   immediate width; imm=IR[IMM_W-1:0], immediate-mode bit=IR[IMM_W]
//  ADDR_W   11  data/jump address width; addr=IR[ADDR_W-1:0]
//  COND_W   3   jump condition mask width; cond=IR[INSTR_W-OPC_W-2 -: COND_W]
// PORTS
//  clock        in   1       system clock, rising edge
//  clear        in   1       asynchronous reset, active-high
//  instr        in   INSTR_W instruction word from instruction memory
//  instr_ready  in   1       instr valid this cycle (fetch handshake)
//  mem_ready    in   1       data memory completed access (see CONFIGURATION)
//  flags        in   COND_W  ALU status flags {N,C,Z} from last CMP/ALU op
//  instr_req    out  1       fetch request, held until instr_ready
//  pc_write     out  1       1-cycle PC update strobe
//  pc_sel_jump  out  1       with pc_write: 1=load jump addr, 0=PC+1
//  rf_we        out  1       register file write enable
//  rf_re1/rf_re2 out 1       register file read enables
//  rd_addr/rs1_addr/rs2_addr out REG_W  write / read-1 / read-2 indices
//  alu_op       out  2       00 ADD,01 AND,10 NAND,11 NOR
//  alu_src_imm  out  1       ALU operand B = sign-extended imm
//  imm          out  IMM_W   immediate field
//  cmp_en       out  1       flag update strobe (CMP)
//  mem_addr     out  ADDR_W  data/jump address
//  mem_re/mem_we out 1       data memory read / write, held until mem_ready
//  wb_sel_mem   out  1       write-back source: 1=memory, 0=ALU
//  busy         out  1       0 only in FETCH with no request outstanding
// BEHAVIOUR
//  States: FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB; state register 3 bits, reset FETCH.
//  clear (async): state=FETCH, IR=0, every output 0; in-flight fetch/memory access abandoned.
//  FETCH: instr_req=1; on instr_ready IR<=instr, ->DECODE; else stay.
//  DECODE (1 cycle): index outputs valid from IR; ALU/CMP/JUMP->EXEC, LD->MEM_RD, ST->MEM_WR.
//  EXEC ALU: alu_op=opcode[1:0]; rf_re1=1, rs1_addr=rs1; ADD/AND with mode bit=1: alu_src_imm=1, rf_re2=0; else rf_re2=1, rs2_addr=rs2; ->WB.
//  EXEC CMP: rf_re1/rf_re2=1, rs1_addr=rd field, rs2_addr=rs1 field, cmp_en=1, pc_write=1 (PC+1); ->FETCH.
//  EXEC JUMP: pc_write=1; pc_sel_jump=1 iff cond==0 (unconditional) or |(cond & flags); ->FETCH.
//  MEM_RD: mem_re=1, mem_addr=addr; on mem_ready ->WB with wb_sel_mem=1.
//  MEM_WR: mem_we=1, rf_re1=1, rs1_addr=rd field; on mem_ready pc_write=1 ->FETCH.
//  WB: rf_we=1, rd_addr=rd field, pc_write=1 (PC+1); ->FETCH.
//  Latency (zero wait): ALU/LD 4 cycles, ST/CMP/JUMP 3 cycles; +1 per cycle mem_ready/instr_ready low.
//  All controls registered on next-state: glitch-free, valid from first cycle of state. Unused fields hold 0.
//  instr changing outside the FETCH handshake has no effect. flags sampled only in EXEC of JUMP.
//  Only one of mem_re/mem_we/rf_we/pc_write-jump active per cycle; no two states ever overlap.
// CONFIGURATION
//  CU_MEM_HANDSHAKE_EN defined: MEM_RD/MEM_WR wait for mem_ready as above.
//  Not defined: mem_ready ignored; MEM_RD/MEM_WR last exactly one cycle (fixed-latency SRAM).
// STRUCTURE
//  cu_pkg: state localparams, opcode localparams, alu_op codes, field-offset functions.
//  Sub-module cu_decoder: combinational IR -> op-class one-hots + field slices; top holds FSM + output regs.
// TESTING
//  ADD r3,r1,r2 (IR=18'b000_0011_0001_0_00_0010), instr_ready immediately -> rf_we in cycle 4, rd_addr=3, rs1=1, rs2=2, alu_op=00.
//  ADDI r5,r4,#-3 -> alu_src_imm=1, rf_re2=0, imm=6'b111101, rd_addr=5.
//  LD r7,@0x055 with mem_ready low 2 cycles (EN set) -> mem_re held 3 cycles, then rf_we, wb_sel_mem=1.
//  JUMP cond=001 flags=001 -> pc_sel_jump=1, mem_addr=addr; flags=110 -> pc_write with pc_sel_jump=0.
//  clear asserted mid-MEM_RD -> same cycle mem_re=0, all outputs 0; next fetch starts at FETCH with instr_req.
//  Back-to-back ST then CMP with instr_ready delayed 1 cycle -> instr_req held 2 cycles, no pc_write while waiting.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the multicycle control unit: FSM states, opcodes,
// ALU operation codes and instruction field positions.
package cu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM_RD = 3'd3,
        ST_MEM_WR = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    localparam logic [2:0] OPC_ADD  = 3'b000;
    localparam logic [2:0] OPC_AND  = 3'b001;
    localparam logic [2:0] OPC_NAND = 3'b010;
    localparam logic [2:0] OPC_NOR  = 3'b011;
    localparam logic [2:0] OPC_LD   = 3'b100;
    localparam logic [2:0] OPC_ST   = 3'b101;
    localparam logic [2:0] OPC_CMP  = 3'b110;
    localparam logic [2:0] OPC_JUMP = 3'b111;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_AND  = 2'b01;
    localparam logic [1:0] ALU_NAND = 2'b10;
    localparam logic [1:0] ALU_NOR  = 2'b11;

    function automatic int f_rd_msb(input int instr_w, input int opc_w);
        return instr_w - opc_w - 1;
    endfunction

    function automatic int f_rs1_msb(input int instr_w, input int opc_w, input int reg_w);
        return instr_w - opc_w - reg_w - 1;
    endfunction

    // The jump condition mask sits one bit below the top of the rd field.
    function automatic int f_cond_msb(input int instr_w, input int opc_w);
        return instr_w - opc_w - 2;
    endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational instruction decoder: IR -> op-class flags and field slices.
module cu_decoder
    import cu_pkg::*;
#(
    parameter int INSTR_W = 18,
    parameter int OPC_W   = 3,
    parameter int REG_W   = 4,
    parameter int IMM_W   = 6,
    parameter int ADDR_W  = 11,
    parameter int COND_W  = 3
) (
    input  logic [INSTR_W-1:0] i_ir,
    output logic               o_is_alu,
    output logic               o_is_cmp,
    output logic               o_is_jump,
    output logic               o_is_ld,
    output logic               o_is_st,
    output logic               o_use_imm,
    output logic [1:0]         o_alu_op,
    output logic [REG_W-1:0]   o_rd,
    output logic [REG_W-1:0]   o_rs1,
    output logic [REG_W-1:0]   o_rs2,
    output logic [IMM_W-1:0]   o_imm,
    output logic [ADDR_W-1:0]  o_addr,
    output logic [COND_W-1:0]  o_cond
);
    localparam int RD_MSB   = f_rd_msb(INSTR_W, OPC_W);
    localparam int RS1_MSB  = f_rs1_msb(INSTR_W, OPC_W, REG_W);
    localparam int COND_MSB = f_cond_msb(INSTR_W, OPC_W);

    logic [OPC_W-1:0] w_opc;

    assign w_opc     = i_ir[INSTR_W-1 -: OPC_W];
    assign o_rd      = i_ir[RD_MSB -: REG_W];
    assign o_rs1     = i_ir[RS1_MSB -: REG_W];
    assign o_rs2     = i_ir[REG_W-1:0];
    assign o_imm     = i_ir[IMM_W-1:0];
    assign o_addr    = i_ir[ADDR_W-1:0];
    assign o_cond    = i_ir[COND_MSB -: COND_W];
    assign o_alu_op  = w_opc[1:0];

    // Opcodes 000..011 are the four ALU operations.
    assign o_is_alu  = (w_opc[OPC_W-1] == 1'b0);
    assign o_is_ld   = (w_opc == OPC_W'(OPC_LD));
    assign o_is_st   = (w_opc == OPC_W'(OPC_ST));
    assign o_is_cmp  = (w_opc == OPC_W'(OPC_CMP));
    assign o_is_jump = (w_opc == OPC_W'(OPC_JUMP));
    // Only ADD and AND honour the immediate-mode bit.
    assign o_use_imm = o_is_alu && !w_opc[1] && i_ir[IMM_W];

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the 18-bit register CPU; all controls registered.
// Optional macro CU_MEM_HANDSHAKE_EN: MEM_RD/MEM_WR wait for i_mem_ready.
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int INSTR_W = 18,
    parameter int OPC_W   = 3,
    parameter int REG_W   = 4,
    parameter int IMM_W   = 6,
    parameter int ADDR_W  = 11,
    parameter int COND_W  = 3
) (
    input  logic               i_clock,
    input  logic               i_clear,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_instr_ready,
    input  logic               i_mem_ready,
    input  logic [COND_W-1:0]  i_flags,
    output logic               o_instr_req,
    output logic               o_pc_write,
    output logic               o_pc_sel_jump,
    output logic               o_rf_we,
    output logic               o_rf_re1,
    output logic               o_rf_re2,
    output logic [REG_W-1:0]   o_rd_addr,
    output logic [REG_W-1:0]   o_rs1_addr,
    output logic [REG_W-1:0]   o_rs2_addr,
    output logic [1:0]         o_alu_op,
    output logic               o_alu_src_imm,
    output logic [IMM_W-1:0]   o_imm,
    output logic               o_cmp_en,
    output logic [ADDR_W-1:0]  o_mem_addr,
    output logic               o_mem_re,
    output logic               o_mem_we,
    output logic               o_wb_sel_mem,
    output logic               o_busy
);
    typedef struct packed {
        logic              instr_req;
        logic              pc_write;
        logic              pc_sel_jump;
        logic              rf_we;
        logic              rf_re1;
        logic              rf_re2;
        logic [REG_W-1:0]  rd_addr;
        logic [REG_W-1:0]  rs1_addr;
        logic [REG_W-1:0]  rs2_addr;
        logic [1:0]        alu_op;
        logic              alu_src_imm;
        logic [IMM_W-1:0]  imm;
        logic              cmp_en;
        logic [ADDR_W-1:0] mem_addr;
        logic              mem_re;
        logic              mem_we;
        logic              wb_sel_mem;
        logic              busy;
    } ctl_t;

    state_t              r_state, w_next;
    ctl_t                r_ctl, w_ctl;
    logic [INSTR_W-1:0]  r_ir, w_ir_next;
    logic                w_fetch_acc, w_mem_done;
    logic                w_is_alu, w_is_cmp, w_is_jump, w_is_ld, w_is_st, w_use_imm;
    logic [1:0]          w_alu_op;
    logic [REG_W-1:0]    w_rd, w_rs1, w_rs2;
    logic [IMM_W-1:0]    w_imm;
    logic [ADDR_W-1:0]   w_addr;
    logic [COND_W-1:0]   w_cond;

    assign w_fetch_acc = (r_state == ST_FETCH) && r_ctl.instr_req && i_instr_ready;
    // Decode the word being latched so DECODE controls are ready on entry.
    assign w_ir_next   = w_fetch_acc ? i_instr : r_ir;

`ifdef CU_MEM_HANDSHAKE_EN
    assign w_mem_done = i_mem_ready;
`else
    // Fixed-latency SRAM: every access completes in one cycle.
    assign w_mem_done = 1'b1 | i_mem_ready;
`endif

    cu_decoder #(
        .INSTR_W(INSTR_W), .OPC_W(OPC_W), .REG_W(REG_W),
        .IMM_W(IMM_W), .ADDR_W(ADDR_W), .COND_W(COND_W)
    ) u_dec (
        .i_ir      (w_ir_next),
        .o_is_alu  (w_is_alu),
        .o_is_cmp  (w_is_cmp),
        .o_is_jump (w_is_jump),
        .o_is_ld   (w_is_ld),
        .o_is_st   (w_is_st),
        .o_use_imm (w_use_imm),
        .o_alu_op  (w_alu_op),
        .o_rd      (w_rd),
        .o_rs1     (w_rs1),
        .o_rs2     (w_rs2),
        .o_imm     (w_imm),
        .o_addr    (w_addr),
        .o_cond    (w_cond)
    );

    always_ff @(posedge i_clock or posedge i_clear) begin
        if (i_clear) begin
            r_state <= ST_FETCH;
            r_ir    <= '0;
            r_ctl   <= '0;
        end else begin
            r_state <= w_next;
            r_ir    <= w_ir_next;
            r_ctl   <= w_ctl;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:  if (w_fetch_acc) w_next = ST_DECODE;
            ST_DECODE: begin
                if (w_is_ld)      w_next = ST_MEM_RD;
                else if (w_is_st) w_next = ST_MEM_WR;
                else              w_next = ST_EXEC;
            end
            ST_EXEC:   w_next = w_is_alu ? ST_WB : ST_FETCH;
            ST_MEM_RD: if (w_mem_done) w_next = ST_WB;
            ST_MEM_WR: if (w_mem_done) w_next = ST_FETCH;
            ST_WB:     w_next = ST_FETCH;
            default:   w_next = ST_FETCH;
        endcase
    end

    // Controls are computed for the state being entered and registered.
    always_comb begin
        w_ctl      = '0;
        w_ctl.busy = 1'b1;
        case (w_next)
            ST_FETCH: begin
                w_ctl.instr_req = 1'b1;
`ifdef CU_MEM_HANDSHAKE_EN
                // Store completion is only known on mem_ready, so PC+1 lands here.
                if (r_state == ST_MEM_WR) w_ctl.pc_write = 1'b1;
`endif
            end
            ST_DECODE: begin
                w_ctl.rd_addr  = w_rd;
                w_ctl.rs1_addr = w_rs1;
                w_ctl.rs2_addr = w_rs2;
            end
            ST_EXEC: begin
                if (w_is_alu) begin
                    w_ctl.alu_op   = w_alu_op;
                    w_ctl.rf_re1   = 1'b1;
                    w_ctl.rs1_addr = w_rs1;
                    if (w_use_imm) begin
                        w_ctl.alu_src_imm = 1'b1;
                        w_ctl.imm         = w_imm;
                    end else begin
                        w_ctl.rf_re2   = 1'b1;
                        w_ctl.rs2_addr = w_rs2;
                    end
                end else if (w_is_cmp) begin
                    w_ctl.rf_re1   = 1'b1;
                    w_ctl.rf_re2   = 1'b1;
                    w_ctl.rs1_addr = w_rd;
                    w_ctl.rs2_addr = w_rs1;
                    w_ctl.cmp_en   = 1'b1;
                    w_ctl.pc_write = 1'b1;
                end else if (w_is_jump) begin
                    w_ctl.pc_write    = 1'b1;
                    w_ctl.mem_addr    = w_addr;
                    w_ctl.pc_sel_jump = (w_cond == '0) || (|(w_cond & i_flags));
                end
            end
            ST_MEM_RD: begin
                w_ctl.mem_re   = 1'b1;
                w_ctl.mem_addr = w_addr;
            end
            ST_MEM_WR: begin
                w_ctl.mem_we   = 1'b1;
                w_ctl.mem_addr = w_addr;
                w_ctl.rf_re1   = 1'b1;
                w_ctl.rs1_addr = w_rd;
`ifndef CU_MEM_HANDSHAKE_EN
                w_ctl.pc_write = 1'b1;
`endif
            end
            ST_WB: begin
                w_ctl.rf_we      = 1'b1;
                w_ctl.rd_addr    = w_rd;
                w_ctl.pc_write   = 1'b1;
                w_ctl.wb_sel_mem = (r_state == ST_MEM_RD);
            end
            default: w_ctl = '0;
        endcase
    end

    assign o_instr_req   = r_ctl.instr_req;
    assign o_pc_write    = r_ctl.pc_write;
    assign o_pc_sel_jump = r_ctl.pc_sel_jump;
    assign o_rf_we       = r_ctl.rf_we;
    assign o_rf_re1      = r_ctl.rf_re1;
    assign o_rf_re2      = r_ctl.rf_re2;
    assign o_rd_addr     = r_ctl.rd_addr;
    assign o_rs1_addr    = r_ctl.rs1_addr;
    assign o_rs2_addr    = r_ctl.rs2_addr;
    assign o_alu_op      = r_ctl.alu_op;
    assign o_alu_src_imm = r_ctl.alu_src_imm;
    assign o_imm         = r_ctl.imm;
    assign o_cmp_en      = r_ctl.cmp_en;
    assign o_mem_addr    = r_ctl.mem_addr;
    assign o_mem_re      = r_ctl.mem_re;
    assign o_mem_we      = r_ctl.mem_we;
    assign o_wb_sel_mem  = r_ctl.wb_sel_mem;
    assign o_busy        = r_ctl.busy;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed, table-driven bench for multicycle_control_unit.
module tb_multicycle_control_unit;

`ifdef CU_MEM_HANDSHAKE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    typedef struct packed {
        logic        instr_req;
        logic        pc_write;
        logic        pc_sel;
        logic        rf_we;
        logic        re1;
        logic        re2;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [1:0]  alu_op;
        logic        src_imm;
        logic [5:0]  imm;
        logic        cmp_en;
        logic [10:0] maddr;
        logic        mre;
        logic        mwe;
        logic        wbm;
        logic        busy;
    } obs_t;

    typedef struct {
        logic [17:0] instr;
        logic [2:0]  flags;
        int          len;
        obs_t        dec;
        obs_t        ex;
        obs_t        last;
    } vec_t;

    logic        clk, clear, instr_ready, mem_ready;
    logic [17:0] instr;
    logic [2:0]  flags;
    logic        instr_req, pc_write, pc_sel_jump, rf_we, rf_re1, rf_re2;
    logic [3:0]  rd_addr, rs1_addr, rs2_addr;
    logic [1:0]  alu_op;
    logic        alu_src_imm, cmp_en, mem_re, mem_we, wb_sel_mem, busy;
    logic [5:0]  imm;
    logic [10:0] mem_addr;
    obs_t        obs;
    int          n_pass, n_total;
    vec_t        vt[12];

    multicycle_control_unit dut (
        .i_clock       (clk),
        .i_clear       (clear),
        .i_instr       (instr),
        .i_instr_ready (instr_ready),
        .i_mem_ready   (mem_ready),
        .i_flags       (flags),
        .o_instr_req   (instr_req),
        .o_pc_write    (pc_write),
        .o_pc_sel_jump (pc_sel_jump),
        .o_rf_we       (rf_we),
        .o_rf_re1      (rf_re1),
        .o_rf_re2      (rf_re2),
        .o_rd_addr     (rd_addr),
        .o_rs1_addr    (rs1_addr),
        .o_rs2_addr    (rs2_addr),
        .o_alu_op      (alu_op),
        .o_alu_src_imm (alu_src_imm),
        .o_imm         (imm),
        .o_cmp_en      (cmp_en),
        .o_mem_addr    (mem_addr),
        .o_mem_re      (mem_re),
        .o_mem_we      (mem_we),
        .o_wb_sel_mem  (wb_sel_mem),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        obs = '0;
        obs.instr_req = instr_req;
        obs.pc_write  = pc_write;
        obs.pc_sel    = pc_sel_jump;
        obs.rf_we     = rf_we;
        obs.re1       = rf_re1;
        obs.re2       = rf_re2;
        obs.rd        = rd_addr;
        obs.rs1       = rs1_addr;
        obs.rs2       = rs2_addr;
        obs.alu_op    = alu_op;
        obs.src_imm   = alu_src_imm;
        obs.imm       = imm;
        obs.cmp_en    = cmp_en;
        obs.maddr     = mem_addr;
        obs.mre       = mem_re;
        obs.mwe       = mem_we;
        obs.wbm       = wb_sel_mem;
        obs.busy      = busy;
    end

    function automatic obs_t o_dec(input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
        return '{rd: rd, rs1: rs1, rs2: rs2, busy: 1'b1, default: 0};
    endfunction

    function automatic obs_t o_wb(input logic [3:0] rd, input logic m);
        return '{rf_we: 1'b1, rd: rd, pc_write: 1'b1, wbm: m, busy: 1'b1, default: 0};
    endfunction

    function automatic obs_t o_fetch(input logic pcw);
        return '{instr_req: 1'b1, pc_write: pcw, busy: 1'b1, default: 0};
    endfunction

    function automatic obs_t o_jump(input logic sel, input logic [10:0] a);
        return '{pc_write: 1'b1, pc_sel: sel, maddr: a, busy: 1'b1, default: 0};
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_pass = 0;
        n_total = 0;

        vt[0]  = '{18'b000_0011_0001_0_00_0010, 3'b000, 4, o_dec(3, 1, 2),
                   '{re1: 1'b1, rs1: 4'd1, re2: 1'b1, rs2: 4'd2, busy: 1'b1, default: 0}, o_wb(3, 1'b0)};
        vt[1]  = '{18'b000_0101_0100_1_111101, 3'b000, 4, o_dec(5, 4, 13),
                   '{re1: 1'b1, rs1: 4'd4, src_imm: 1'b1, imm: 6'b111101, busy: 1'b1, default: 0}, o_wb(5, 1'b0)};
        vt[2]  = '{18'b011_0010_0110_1_00_1001, 3'b000, 4, o_dec(2, 6, 9),
                   '{re1: 1'b1, rs1: 4'd6, re2: 1'b1, rs2: 4'd9, alu_op: 2'd3, busy: 1'b1, default: 0}, o_wb(2, 1'b0)};
        vt[3]  = '{18'b001_0001_0010_1_000101, 3'b000, 4, o_dec(1, 2, 5),
                   '{re1: 1'b1, rs1: 4'd2, alu_op: 2'd1, src_imm: 1'b1, imm: 6'd5, busy: 1'b1, default: 0}, o_wb(1, 1'b0)};
        vt[4]  = '{{3'b100, 4'd7, 11'h055}, 3'b000, 4, o_dec(7, 0, 5),
                   '{mre: 1'b1, maddr: 11'h055, busy: 1'b1, default: 0}, o_wb(7, 1'b1)};
        vt[5]  = '{{3'b101, 4'd9, 11'h7FF}, 3'b000, 3, o_dec(9, 15, 15),
                   '{mwe: 1'b1, re1: 1'b1, rs1: 4'd9, maddr: 11'h7FF, pc_write: !HS, busy: 1'b1, default: 0}, o_fetch(HS)};
        vt[6]  = '{18'b110_0100_1010_0_00_0000, 3'b000, 3, o_dec(4, 10, 0),
                   '{re1: 1'b1, re2: 1'b1, rs1: 4'd4, rs2: 4'd10, cmp_en: 1'b1, pc_write: 1'b1, busy: 1'b1, default: 0},
                   o_fetch(1'b0)};
        vt[7]  = '{{3'b111, 1'b0, 3'b001, 11'h123}, 3'b001, 3, o_dec(1, 2, 3), o_jump(1'b1, 11'h123), o_fetch(1'b0)};
        vt[8]  = '{{3'b111, 1'b0, 3'b001, 11'h123}, 3'b110, 3, o_dec(1, 2, 3), o_jump(1'b0, 11'h123), o_fetch(1'b0)};
        vt[9]  = '{{3'b111, 1'b0, 3'b000, 11'h400}, 3'b000, 3, o_dec(0, 8, 0), o_jump(1'b1, 11'h400), o_fetch(1'b0)};
        vt[10] = '{{3'b111, 1'b0, 3'b110, 11'h00F}, 3'b100, 3, o_dec(6, 0, 15), o_jump(1'b1, 11'h00F), o_fetch(1'b0)};
        vt[11] = '{{3'b111, 1'b0, 3'b010, 11'h0AA}, 3'b101, 3, o_dec(2, 1, 10), o_jump(1'b0, 11'h0AA), o_fetch(1'b0)};

        clear = 1'b1;
        instr = '0;
        instr_ready = 1'b0;
        mem_ready = 1'b1;
        flags = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", obs, '0);
        clear = 1'b0;
        #1;
        check("post_reset_idle", obs, '0);
        tick();
        check("first_fetch", obs, o_fetch(1'b0));

        for (int i = 0; i < 12; i++) begin
            instr = vt[i].instr;
            flags = vt[i].flags;
            instr_ready = 1'b1;
            tick();
            instr_ready = 1'b0;
            instr = 18'h3FFFF;
            check($sformatf("v%0d_decode", i), obs, vt[i].dec);
            tick();
            check($sformatf("v%0d_exec", i), obs, vt[i].ex);
            tick();
            check($sformatf("v%0d_last", i), obs, vt[i].last);
            if (vt[i].len == 4) tick();
            flags = '0;
        end

        // LD r7,@0x055 with mem_ready low for the first two MEM_RD cycles
        mem_ready = 1'b0;
        instr = {3'b100, 4'd7, 11'h055};
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tick();
        n = 0;
        while (obs.mre && n < 10) begin
            n++;
            if (n == 3) mem_ready = 1'b1;
            tick();
        end
        check_int("ld_mem_re_cycles", n, HS ? 3 : 1);
        check("ld_wb", obs, o_wb(7, 1'b1));
        mem_ready = 1'b1;
        tick();
        check("ld_back_to_fetch", obs, o_fetch(1'b0));

        // clear in the middle of MEM_RD
        mem_ready = 1'b0;
        instr = {3'b100, 4'd3, 11'h200};
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tick();
        check("clr_in_mem_rd", obs, '{mre: 1'b1, maddr: 11'h200, busy: 1'b1, default: 0});
        #2;
        clear = 1'b1;
        #1;
        check("clr_async_zero", obs, '0);
        #2;
        clear = 1'b0;
        mem_ready = 1'b1;
        tick();
        check("clr_refetch", obs, o_fetch(1'b0));

        // ST then CMP with instr_ready delayed by one cycle
        instr = {3'b101, 4'd2, 11'h010};
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("st_decode", obs, o_dec(2, 0, 0));
        tick();
        check("st_mem_wr", obs, '{mwe: 1'b1, re1: 1'b1, rs1: 4'd2, maddr: 11'h010, pc_write: !HS, busy: 1'b1, default: 0});
        tick();
        check("wait_fetch_1", obs, o_fetch(HS));
        tick();
        check("wait_fetch_2", obs, o_fetch(1'b0));
        instr = 18'b110_0001_0111_0_00_0000;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("cmp_decode", obs, o_dec(1, 7, 0));
        tick();
        check("cmp_exec", obs, '{re1: 1'b1, re2: 1'b1, rs1: 4'd1, rs2: 4'd7, cmp_en: 1'b1, pc_write: 1'b1, busy: 1'b1, default: 0});
        tick();
        check("cmp_back_to_fetch", obs, o_fetch(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
